// File: rtl/wash_sequencer.sv
// Washer program sequencer: latches a program at start, then steps through
// fill/wash, rinse loops and final drain/spin on the 1 Hz tick, ending in a beep.
module wash_sequencer #(
  parameter logic [3:0] DRAIN_SEC = 4'd2,
  parameter logic [3:0] SPIN_SEC  = 4'd3,
  parameter logic [3:0] RINSE_SEC = 4'd3,
  parameter logic [3:0] BEEP_SEC  = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       run_btn,
  input  logic       door_open,
  input  logic [3:0] wash_time,
  input  logic [1:0] rinse_cnt,
  input  logic [2:0] water_lvl,
  output logic [7:0] phase_led,
  output logic [3:0] phase_remain,
  output logic [1:0] rinse_left,
  output logic       running,
  output logic       paused,
  output logic       done_beep
);

  typedef enum logic [3:0] {
    IDLE, W_FILL, WASH, R_DRAIN, R_SPIN, R_FILL, RINSE, D_DRAIN, D_SPIN, DONE
  } state_t;

  state_t     state, state_nxt, succ;
  logic [3:0] remain, remain_nxt;
  logic [1:0] rl, rl_nxt, rl_dec;
  logic       paused_q, paused_nxt;
  logic [3:0] wash_lat, wash_lat_nxt;
  logic [2:0] water_lat, water_lat_nxt;
  logic       honoured, zero_adv, advance;

  function automatic logic [3:0] duration(input state_t s, input logic [3:0] wash,
                                          input logic [2:0] water);
    case (s)
      W_FILL, R_FILL:   duration = {1'b0, water};
      WASH:             duration = wash;
      R_DRAIN, D_DRAIN: duration = DRAIN_SEC;
      R_SPIN, D_SPIN:   duration = SPIN_SEC;
      RINSE:            duration = RINSE_SEC;
      DONE:             duration = BEEP_SEC;
      default:          duration = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remain    <= 4'd0;
      rl        <= 2'd0;
      paused_q  <= 1'b0;
      wash_lat  <= 4'd0;
      water_lat <= 3'd0;
    end else begin
      state     <= state_nxt;
      remain    <= remain_nxt;
      rl        <= rl_nxt;
      paused_q  <= paused_nxt;
      wash_lat  <= wash_lat_nxt;
      water_lat <= water_lat_nxt;
    end
  end

  // Successor of the current phase; RINSE consumes one loop as it exits.
  always_comb begin
    rl_dec = rl - 2'd1;
    succ   = IDLE;
    case (state)
      W_FILL:  succ = WASH;
      WASH:    succ = (rl != 2'd0) ? R_DRAIN : D_DRAIN;
      R_DRAIN: succ = R_SPIN;
      R_SPIN:  succ = R_FILL;
      R_FILL:  succ = RINSE;
      RINSE:   succ = (rl_dec != 2'd0) ? R_DRAIN : D_DRAIN;
      D_DRAIN: succ = D_SPIN;
      D_SPIN:  succ = DONE;
      default: succ = IDLE;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    remain_nxt    = remain;
    rl_nxt        = rl;
    paused_nxt    = paused_q;
    wash_lat_nxt  = wash_lat;
    water_lat_nxt = water_lat;

    // DONE keeps counting regardless of lid and button.
    honoured = (state != IDLE) && sec_tick &&
               ((state == DONE) || (!paused_q && !door_open && !run_btn));
    zero_adv = (state != IDLE) && (remain == 4'd0) && !paused_q && !door_open;
    advance  = zero_adv || (honoured && (remain == 4'd1));

    if (state == IDLE) begin
      if (run_btn && !door_open) begin
        state_nxt     = W_FILL;
        remain_nxt    = {1'b0, water_lvl};
        rl_nxt        = rinse_cnt;
        wash_lat_nxt  = wash_time;
        water_lat_nxt = water_lvl;
      end
    end else begin
      if (state != DONE && run_btn && !door_open)
        paused_nxt = ~paused_q;
      if (advance) begin
        state_nxt  = succ;
        remain_nxt = duration(succ, wash_lat, water_lat);
        if (state == RINSE)
          rl_nxt = rl_dec;
        if (succ == IDLE) begin
          rl_nxt     = 2'd0;
          paused_nxt = 1'b0;
        end
      end else if (honoured && remain >= 4'd2) begin
        remain_nxt = remain - 4'd1;
      end
    end
  end

  always_comb begin
    phase_led = 8'h00;
    case (state)
      W_FILL:  phase_led = 8'h80;
      WASH:    phase_led = 8'h40;
      R_DRAIN: phase_led = 8'h20;
      R_SPIN:  phase_led = 8'h10;
      R_FILL:  phase_led = 8'h08;
      RINSE:   phase_led = 8'h04;
      D_DRAIN: phase_led = 8'h02;
      D_SPIN:  phase_led = 8'h01;
      default: phase_led = 8'h00;
    endcase
  end

  assign phase_remain = remain;
  assign rinse_left   = rl;
  assign running      = (state != IDLE);
  assign paused       = paused_q;
  assign done_beep    = (state == DONE);

endmodule
